// File: rtl/segment_elastic_ex_mem.sv
// Elastic EX/MEM pipeline segment: two-entry skid buffer (main + skid) with valid/ready, flush and falling-edge state.
// Optional macro SEGMENT_BUBBLE_CTRL_KILL_EN zeroes out_ctrl/out_lane_mask whenever out_valid is low.
module segment_elastic_ex_mem #(
  parameter int DATA_W = 192,
  parameter int LANES  = 8,
  parameter int RD_W   = 4,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_store,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [LANES-1:0]  in_lane_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_store,
  output logic [RD_W-1:0]   out_rd,
  output logic [LANES-1:0]  out_lane_mask,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + RD_W + LANES;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic [ENTRY_W-1:0] in_entry;
  logic [LANES-1:0]   lane_mask_cap;
  logic [CTRL_W-1:0]  head_ctrl;
  logic [LANES-1:0]   head_mask;
  logic               in_fire;
  logic               out_fire;

  // Scalar ops write only lane 0, whatever EX drove on the mask bus.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_mask
    if (gi == 0) begin : g_lane0
      assign lane_mask_cap[gi] = in_ctrl[2] ? in_lane_mask[gi] : 1'b1;
    end else begin : g_laneN
      assign lane_mask_cap[gi] = in_ctrl[2] ? in_lane_mask[gi] : 1'b0;
    end
  end

  assign in_entry = {in_ctrl, in_alu, in_store, in_rd, lane_mask_cap};
  assign {head_ctrl, out_alu, out_store, out_rd, head_mask} = main_q;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef SEGMENT_BUBBLE_CTRL_KILL_EN
  assign out_ctrl      = out_valid ? head_ctrl : '0;
  assign out_lane_mask = out_valid ? head_mask : '0;
`else
  assign out_ctrl      = head_ctrl;
  assign out_lane_mask = head_mask;
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_entry;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_entry;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
